// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC instruction-fetch unit.
// Latency: none (types, defaults and a combinational helper only).
// Backpressure: not applicable.
//
// Contents: fetch FSM state encoding, default bus widths and reset vector,
// and the branch-target helper used by both the IDLE and pending-branch paths.
package sisc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_RST_VEC = 0;

    // Branch arithmetic is done at a fixed wide width; callers keep the low
    // ADDR_W bits, which gives the modulo-2^ADDR_W wrap for relative branches.
    localparam int BR_CALC_W = 64;

    function automatic logic [BR_CALC_W-1:0] br_target(
        input logic [BR_CALC_W-1:0] pc,
        input logic                 abs_mode,
        input logic [BR_CALC_W-1:0] imm
    );
        return abs_mode ? imm : pc + imm;
    endfunction

endpackage

// File: rtl/sisc_fetch_timer.sv
// WAIT-state timeout counter for sisc_fetch.
// Latency: expired is combinational from the registered count.
// Backpressure: none; counts while en=1, holds otherwise, clr/rst zero it.
//
// Ports: clk, rst (sync, active-high), clr (zero the count), en (count one
// cycle), expired (count has reached TIMEOUT; constant 0 when TIMEOUT=0).
module sisc_fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_tie;
        assign unused_tie = clk ^ rst ^ clr ^ en;
        assign expired    = 1'b0;
    end else begin : g_on
        localparam int CNT_W = $clog2(TIMEOUT + 1);
        logic [CNT_W-1:0] cnt;

        // The owner leaves WAIT on expiry, so the count never needs to
        // saturate beyond TIMEOUT.
        always_ff @(posedge clk) begin
            if (rst || clr) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign expired = (cnt == CNT_W'(TIMEOUT));
    end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch: PC, branch unit, req/ack memory fetch, IR, timeout fault.
// Latency: fetch_req to ir_valid is 2 cycles minimum, +1 per memory wait cycle.
// Backpressure: fetch_req ignored while busy/faulted; control must wait for ir_valid.
//
// Ports: clk, rst_f (sync, active-high); fetch_req, br_load/br_abs/br_imm
// from control; imem_req/imem_addr/imem_ack/imem_rdata memory handshake;
// ir/ir_valid decoded-instruction bus; pc_out, busy, fault status.
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RST_VEC = ADDR_W'(DEF_RST_VEC),
    parameter int                TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_req,
    input  logic              br_load,
    input  logic              br_abs,
    input  logic [ADDR_W-1:0] br_imm,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              fault
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] ir_n;
    logic              ir_valid_n, req_n, fault_n;
    logic              pend_vld, pend_vld_n;
    logic [ADDR_W-1:0] pend_tgt, pend_tgt_n;
    logic              tmr_clr, tmr_en, tmr_expired;

    // Target relative to the current pc; in WAIT pc still equals imem_addr.
    logic [BR_CALC_W-1:0] br_tgt_full;
    logic [ADDR_W-1:0]    br_tgt;
    logic                 unused_br_hi;
    assign br_tgt_full  = br_target(BR_CALC_W'(pc), br_abs, BR_CALC_W'(br_imm));
    assign br_tgt       = br_tgt_full[ADDR_W-1:0];
    assign unused_br_hi = ^br_tgt_full[BR_CALC_W-1:ADDR_W];

    sisc_fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst_f),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        addr_n     = imem_addr;
        ir_n       = ir;
        ir_valid_n = 1'b0;
        req_n      = imem_req;
        fault_n    = fault;
        pend_vld_n = pend_vld;
        pend_tgt_n = pend_tgt;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (br_load) pc_n = br_tgt;
                if (fetch_req) begin
                    state_n    = ST_WAIT;
                    req_n      = 1'b1;
                    addr_n     = br_load ? br_tgt : pc;
                    tmr_clr    = 1'b1;
                    pend_vld_n = 1'b0;
                end
            end
            ST_WAIT: begin
                if (br_load) begin
                    pend_vld_n = 1'b1;
                    pend_tgt_n = br_tgt;
                end
                // Ack takes priority over a same-cycle timeout expiry.
                if (imem_ack) begin
                    state_n    = ST_IDLE;
                    ir_n       = imem_rdata;
                    ir_valid_n = 1'b1;
                    req_n      = 1'b0;
                    pend_vld_n = 1'b0;
                    if (br_load)       pc_n = br_tgt;
                    else if (pend_vld) pc_n = pend_tgt;
                    else               pc_n = imem_addr + ADDR_W'(1);
                end else if (tmr_expired) begin
                    state_n = ST_FAULT;
                    req_n   = 1'b0;
                    fault_n = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_FAULT: begin
                req_n = 1'b0;
            end
            default: begin
                state_n = ST_IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state     <= ST_IDLE;
            pc        <= RST_VEC;
            imem_addr <= RST_VEC;
            ir        <= '0;
            ir_valid  <= 1'b0;
            imem_req  <= 1'b0;
            fault     <= 1'b0;
            pend_vld  <= 1'b0;
            pend_tgt  <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            imem_addr <= addr_n;
            ir        <= ir_n;
            ir_valid  <= ir_valid_n;
            imem_req  <= req_n;
            fault     <= fault_n;
            pend_vld  <= pend_vld_n;
            pend_tgt  <= pend_tgt_n;
        end
    end

    assign pc_out = pc;
    assign busy   = (state == ST_WAIT);

endmodule

// File: tb/tb_sisc_fetch.sv
// Testbench for sisc_fetch: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_sisc_fetch;

    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        rst_f = 1'b1;
    logic        fetch_req = 1'b0;
    logic        br_load = 1'b0;
    logic        br_abs = 1'b0;
    logic [15:0] br_imm = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        ir_valid;
    logic [15:0] pc_out;
    logic        busy;
    logic        fault;

    always #5 clk = ~clk;

    sisc_fetch #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .fetch_req  (fetch_req),
        .br_load    (br_load),
        .br_abs     (br_abs),
        .br_imm     (br_imm),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .pc_out     (pc_out),
        .busy       (busy),
        .fault      (fault)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: an outstanding-fetch flag, the cycle it was issued,
    // and a single optional redirect target.
    bit          m_busy, m_fault, m_irv, p_vld;
    logic [15:0] m_pc, m_addr, p_tgt;
    logic [31:0] m_ir;
    int          cyc = 0;
    int          issue_cyc = 0;

    function automatic logic [15:0] target(input logic [15:0] cur);
        return br_abs ? br_imm : cur + br_imm;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        m_irv = 1'b0;
        if (rst_f) begin
            m_busy = 0; m_fault = 0; p_vld = 0;
            m_pc = 16'h0; m_addr = 16'h0; m_ir = 32'h0;
        end else if (m_fault) begin
            // everything ignored until reset
        end else if (!m_busy) begin
            if (br_load) m_pc = target(m_pc);
            if (fetch_req) begin
                m_busy = 1; m_addr = m_pc; issue_cyc = cyc; p_vld = 0;
            end
        end else begin
            if (br_load) begin
                p_vld = 1; p_tgt = target(m_pc);
            end
            if (imem_ack) begin
                m_ir = imem_rdata; m_irv = 1; m_busy = 0;
                m_pc = p_vld ? p_tgt : m_addr + 16'd1;
                p_vld = 0;
            end else if (cyc - issue_cyc == TO + 1) begin
                m_fault = 1; m_busy = 0;
            end
        end
        #1;
        check("imem_req", imem_req, m_busy);
        check("busy", busy, m_busy);
        check("fault", fault, m_fault);
        check("pc_out", pc_out, m_pc);
        check("imem_addr", imem_addr, m_addr);
        check("ir_valid", ir_valid, m_irv);
        check("ir", ir, m_ir);
    endtask

    task automatic drive(input bit r, input bit f, input bit bl, input bit ba,
                         input logic [15:0] bi, input bit a, input logic [31:0] d);
        rst_f = r; fetch_req = f; br_load = bl; br_abs = ba; br_imm = bi;
        imem_ack = a; imem_rdata = d;
        step();
    endtask

    initial begin
        // Reset and plain fetch
        drive(1, 0, 0, 0, 16'h0, 0, 32'h0);
        check("rst_pc", pc_out, 16'h0);
        check("rst_addr", imem_addr, 16'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_ir", ir, 32'h0);
        drive(0, 1, 0, 0, 16'h0, 0, 32'h0);
        check("f1_req", imem_req, 1'b1);
        check("f1_addr", imem_addr, 16'h0);
        drive(0, 0, 0, 0, 16'h0, 1, 32'h1234_5678);
        check("f1_ir", ir, 32'h1234_5678);
        check("f1_irv", ir_valid, 1'b1);
        check("f1_pc", pc_out, 16'h1);
        drive(0, 0, 0, 0, 16'h0, 0, 32'h0);
        check("f1_irv_pulse", ir_valid, 1'b0);

        // Relative branch with same-cycle fetch
        drive(0, 0, 1, 1, 16'h5, 0, 32'h0);
        check("b_pc5", pc_out, 16'h5);
        drive(0, 1, 1, 0, 16'hFFFE, 0, 32'h0);
        check("b_addr", imem_addr, 16'h3);
        drive(0, 0, 0, 0, 16'h0, 1, 32'h0BAD_0003);
        check("b_pc", pc_out, 16'h4);

        // Wrap-around and absolute branch
        drive(0, 0, 1, 1, 16'hFFFF, 0, 32'h0);
        drive(0, 1, 0, 0, 16'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 16'h0, 1, 32'h0000_FFFF);
        check("wrap_pc", pc_out, 16'h0);
        drive(0, 0, 1, 1, 16'h0040, 0, 32'h0);
        check("abs_pc", pc_out, 16'h0040);

        // Branch in WAIT, ack on the same edge the timeout would fire
        drive(0, 0, 1, 1, 16'h8, 0, 32'h0);
        drive(0, 1, 0, 0, 16'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 16'h0, 0, 32'h0);
        drive(0, 0, 1, 1, 16'h0100, 0, 32'h0);
        check("bw_pc_hold", pc_out, 16'h8);
        drive(0, 1, 0, 0, 16'h0, 0, 32'h0);
        check("bw_addr", imem_addr, 16'h8);
        drive(0, 0, 0, 0, 16'h0, 1, 32'hCAFE_F00D);
        check("bw_ir", ir, 32'hCAFE_F00D);
        check("bw_pc", pc_out, 16'h0100);
        check("bw_nofault", fault, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 0, 32'h0);
        check("bw_no_refetch", imem_req, 1'b0);

        // Timeout
        drive(0, 1, 0, 0, 16'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 16'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 16'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 16'h0, 0, 32'h0);
        check("to_pre", fault, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 0, 32'h0);
        check("to_fault", fault, 1'b1);
        check("to_req", imem_req, 1'b0);
        drive(0, 1, 0, 0, 16'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 16'h0, 1, 32'h5555_AAAA);
        check("to_ign_irv", ir_valid, 1'b0);
        check("to_ign_req", imem_req, 1'b0);
        drive(1, 0, 0, 0, 16'h0, 0, 32'h0);
        check("to_clr", fault, 1'b0);

        // Reset mid-WAIT
        drive(0, 0, 1, 1, 16'h0077, 0, 32'h0);
        drive(0, 1, 0, 0, 16'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 16'h0, 0, 32'h0);
        drive(1, 0, 0, 0, 16'h0, 0, 32'h0);
        check("rw_req", imem_req, 1'b0);
        check("rw_pc", pc_out, 16'h0);
        drive(0, 0, 0, 0, 16'h0, 1, 32'hDEAD_BEEF);
        check("rw_late_ack", ir_valid, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1,
                  16'($urandom),
                  $urandom_range(0, 1) == 1,
                  $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
